// File: rtl/odelay_pipe_loader.sv
// odelay_pipe_loader
//   Stages per-lane output-delay settings into the ODELAYE2 FINEDELAY pipeline
//   registers and applies all lanes together with one shared LD pulse, so every
//   DQ/DQS output delay of a byte group changes on the same clock edge.
//
// Ports
//   clk, rst          clock (also drives the primitives' C input), sync active-high reset
//   cmd_valid/ready   command handshake; accept on valid && ready
//   cmd_op            0 = stage cmd_delay into cmd_lane, 1 = commit all staged lanes
//   cmd_lane          stage target lane
//   cmd_delay         {coarse[4:0], fine[2:0]}
//   odly_cntvalue     per-lane CNTVALUEIN, lane i at [5i+4:5i]
//   odly_ldpipeen     per-lane LDPIPEEN pulse
//   odly_ld           shared LD pulse
//   odly_fine         per-lane OFDLY, lane i at [3i+2:3i]
//   dirty             lanes staged but not committed
//   busy              commit or settle in progress
//   bad_lane          sticky: a stage targeted a lane >= LANES
//   rd_lane/rd_delay  registered readback of the applied delay
//
// State table
//   IDLE   | ready for a command
//   STAGE  | one-cycle slot after a stage (LDPIPEEN pulse) or an empty commit
//   COMMIT | LD pulse cycle; fine/applied take the staged values on its closing edge
//   SETTLE | busy hold-off while the delay lines settle

module odelay_pipe_loader #(
    parameter int          LANES         = 8,
    parameter logic [7:0]  DELAY_VALUE   = 8'h00,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [3:0]           cmd_lane,
    input  logic [7:0]           cmd_delay,
    output logic [5*LANES-1:0]   odly_cntvalue,
    output logic [LANES-1:0]     odly_ldpipeen,
    output logic                 odly_ld,
    output logic [3*LANES-1:0]   odly_fine,
    output logic [LANES-1:0]     dirty,
    output logic                 busy,
    output logic                 bad_lane,
    input  logic [3:0]           rd_lane,
    output logic [7:0]           rd_delay
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STAGE  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [LANES-1:0][4:0]   coarse_q, coarse_d;
    logic [LANES-1:0][2:0]   fine_pre_q, fine_pre_d;
    logic [LANES-1:0][2:0]   fine_q, fine_d;
    logic [LANES-1:0][7:0]   staged_q, staged_d;
    logic [LANES-1:0][7:0]   applied_q, applied_d;
    logic [LANES-1:0]        dirty_q, dirty_d;
    logic [LANES-1:0]        ldpipeen_q, ldpipeen_d;
    logic                    ld_q, ld_d;
    logic                    bad_q, bad_d;
    logic [7:0]              rd_delay_q, rd_delay_d;
    logic [LANES-1:0]        lane_hit;

    assign cmd_ready     = (state_q == S_IDLE) && !rst;
    assign odly_cntvalue = coarse_q;
    assign odly_fine     = fine_q;
    assign odly_ldpipeen = ldpipeen_q;
    assign odly_ld       = ld_q;
    assign dirty         = dirty_q;
    assign busy          = (state_q == S_COMMIT) || (state_q == S_SETTLE);
    assign bad_lane      = bad_q;
    assign rd_delay      = rd_delay_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        coarse_d   = coarse_q;
        fine_pre_d = fine_pre_q;
        fine_d     = fine_q;
        staged_d   = staged_q;
        applied_d  = applied_q;
        dirty_d    = dirty_q;
        ldpipeen_d = '0;
        ld_d       = 1'b0;
        bad_d      = bad_q;
        rd_delay_d = 8'h00;
        lane_hit   = '0;

        // Decoding by loop keeps out-of-range lanes from aliasing onto real ones.
        for (int i = 0; i < LANES; i++) begin
            lane_hit[i] = (cmd_lane == 4'(i));
            if (rd_lane == 4'(i)) begin
                rd_delay_d = applied_q[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_op) begin
                        state_d = S_STAGE;
                        if (|lane_hit) begin
                            for (int i = 0; i < LANES; i++) begin
                                if (lane_hit[i]) begin
                                    coarse_d[i]   = cmd_delay[7:3];
                                    fine_pre_d[i] = cmd_delay[2:0];
                                    staged_d[i]   = cmd_delay;
                                    dirty_d[i]    = 1'b1;
                                end
                            end
                            // Registered so the pulse lands in the STAGE cycle.
                            ldpipeen_d = lane_hit;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end else if (|dirty_q) begin
                        state_d = S_COMMIT;
                        ld_d    = 1'b1;
                    end else begin
                        // Nothing staged: burn one cycle without touching LD.
                        state_d = S_STAGE;
                    end
                end
            end
            S_STAGE: begin
                state_d = S_IDLE;
            end
            S_COMMIT: begin
                // Closing edge coincides with the primitive sampling LD.
                fine_d    = fine_pre_q;
                applied_d = staged_q;
                dirty_d   = '0;
                cnt_d     = 4'(SETTLE_CYCLES - 1);
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            coarse_q   <= {LANES{DELAY_VALUE[7:3]}};
            fine_pre_q <= {LANES{DELAY_VALUE[2:0]}};
            fine_q     <= {LANES{DELAY_VALUE[2:0]}};
            staged_q   <= {LANES{DELAY_VALUE}};
            applied_q  <= {LANES{DELAY_VALUE}};
            dirty_q    <= '0;
            ldpipeen_q <= '0;
            ld_q       <= 1'b0;
            bad_q      <= 1'b0;
            rd_delay_q <= DELAY_VALUE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coarse_q   <= coarse_d;
            fine_pre_q <= fine_pre_d;
            fine_q     <= fine_d;
            staged_q   <= staged_d;
            applied_q  <= applied_d;
            dirty_q    <= dirty_d;
            ldpipeen_q <= ldpipeen_d;
            ld_q       <= ld_d;
            bad_q      <= bad_d;
            rd_delay_q <= rd_delay_d;
        end
    end

endmodule

// File: tb/tb_odelay_pipe_loader.sv
// tb_odelay_pipe_loader
//   Directed and randomized commands against a transaction-level model of the
//   lane delays (staged / applied / dirty / bad_lane) plus expected handshake
//   timing per command type.

module tb_odelay_pipe_loader;

    localparam int         LANES  = 8;
    localparam logic [7:0] DV     = 8'h2B;
    localparam int         SETTLE = 4;

    logic                clk;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [3:0]          cmd_lane;
    logic [7:0]          cmd_delay;
    logic [5*LANES-1:0]  odly_cntvalue;
    logic [LANES-1:0]    odly_ldpipeen;
    logic                odly_ld;
    logic [3*LANES-1:0]  odly_fine;
    logic [LANES-1:0]    dirty;
    logic                busy;
    logic                bad_lane;
    logic [3:0]          rd_lane;
    logic [7:0]          rd_delay;

    odelay_pipe_loader #(
        .LANES         (LANES),
        .DELAY_VALUE   (DV),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_lane      (cmd_lane),
        .cmd_delay     (cmd_delay),
        .odly_cntvalue (odly_cntvalue),
        .odly_ldpipeen (odly_ldpipeen),
        .odly_ld       (odly_ld),
        .odly_fine     (odly_fine),
        .dirty         (dirty),
        .busy          (busy),
        .bad_lane      (bad_lane),
        .rd_lane       (rd_lane),
        .rd_delay      (rd_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    // Reference model: what each lane holds at transaction level.
    logic [7:0] staged_m  [LANES];
    logic [7:0] applied_m [LANES];
    logic [7:0] dirty_m;
    logic       bad_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [39:0] exp_cnt();
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[5*i +: 5] = staged_m[i][7:3];
        return r;
    endfunction

    function automatic logic [23:0] exp_fine();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[3*i +: 3] = applied_m[i][2:0];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            staged_m[i]  = DV;
            applied_m[i] = DV;
        end
        dirty_m = '0;
        bad_m   = 1'b0;
    endtask

    task automatic send_cmd(input bit op, input logic [3:0] lane, input logic [7:0] dly);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_lane  = lane;
        cmd_delay = dly;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_lane  = 4'($urandom);
        cmd_delay = 8'($urandom);
    endtask

    // Watches from the cycle after accept until cmd_ready returns.
    task automatic observe(output int low, output int bsy, output int ldn, output int lpn,
                           output logic [7:0] lpor, output logic [39:0] snap);
        int  n;
        bit  done;
        low = 0; bsy = 0; ldn = 0; lpn = 0; lpor = '0; snap = '0;
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin
                done = 1;
            end else begin
                low++;
                if (busy) bsy++;
                if (odly_ld) ldn++;
                if (|odly_ldpipeen) begin
                    lpn++;
                    lpor = lpor | odly_ldpipeen;
                    snap = odly_cntvalue;
                end
            end
        end
        if (!done) chk("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_cmd(input bit op, input logic [3:0] lane, input logic [7:0] dly);
        int idx, low, bsy, ldn, lpn, e_low, e_busy, e_ld;
        logic [7:0]  lpor, e_lp;
        logic [39:0] snap;
        idx = int'(lane);
        e_lp = '0;
        if (!op) begin
            e_low = 1; e_busy = 0; e_ld = 0;
            if (idx < LANES) begin
                staged_m[idx] = dly;
                dirty_m[idx]  = 1'b1;
                e_lp = 8'(1 << idx);
            end else begin
                bad_m = 1'b1;
            end
        end else if (dirty_m != 0) begin
            e_low = SETTLE + 1; e_busy = SETTLE + 1; e_ld = 1;
            for (int i = 0; i < LANES; i++) applied_m[i] = staged_m[i];
            dirty_m = '0;
        end else begin
            e_low = 1; e_busy = 0; e_ld = 0;
        end
        send_cmd(op, lane, dly);
        observe(low, bsy, ldn, lpn, lpor, snap);
        chk("ready_low_cycles", 64'(low), 64'(e_low));
        chk("busy_cycles", 64'(bsy), 64'(e_busy));
        chk("ld_pulses", 64'(ldn), 64'(e_ld));
        chk("ldpipeen_mask", 64'(lpor), 64'(e_lp));
        chk("ldpipeen_cycles", 64'(lpn), 64'((e_lp != 0) ? 1 : 0));
        if (e_lp != 0) chk("cnt_during_ldpipeen", 64'(snap), 64'(exp_cnt()));
    endtask

    task automatic full_check();
        chk("dirty", 64'(dirty), 64'(dirty_m));
        chk("bad_lane", 64'(bad_lane), 64'(bad_m));
        chk("cntvalue", 64'(odly_cntvalue), 64'(exp_cnt()));
        chk("fine", 64'(odly_fine), 64'(exp_fine()));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("ready_idle", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < LANES; i++) begin
            rd_lane = 4'(i);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rd_delay_lane%0d", i), 64'(rd_delay), 64'(applied_m[i]));
        end
        rd_lane = 4'(LANES + int'($urandom_range(0, 15 - LANES)));
        @(posedge clk);
        @(negedge clk);
        chk("rd_delay_invalid", 64'(rd_delay), 64'(0));
    endtask

    task automatic pulse_reset_and_check();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_dirty", 64'(dirty), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ld", 64'(odly_ld), 64'(0));
        chk("rst_ldpipeen", 64'(odly_ldpipeen), 64'(0));
        chk("rst_cntvalue", 64'(odly_cntvalue), 64'(exp_cnt()));
        chk("rst_fine", 64'(odly_fine), 64'(exp_fine()));
        chk("rst_rd_delay", 64'(rd_delay), 64'(DV));
        chk("rst_ready_low", 64'(cmd_ready), 64'(0));
        rst = 1'b0;
    endtask

    initial begin
        int ldn, bsy, a0, n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_lane  = 4'd0;
        cmd_delay = 8'd0;
        rd_lane   = 4'd0;
        model_reset();

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("ready_during_rst", 64'(cmd_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready), 64'(1));
        chk("reset_cntvalue", 64'(odly_cntvalue), 64'({LANES{5'h05}}));
        chk("reset_fine", 64'(odly_fine), 64'({LANES{3'h3}}));
        chk("reset_rd_delay", 64'(rd_delay), 64'(8'h2B));
        chk("reset_dirty", 64'(dirty), 64'(0));
        full_check();

        // Single lane stage then commit
        do_cmd(1'b0, 4'd2, 8'hA5);
        chk("dirty_after_stage2", 64'(dirty), 64'(8'h04));
        chk("lane2_cnt", 64'(odly_cntvalue[14:10]), 64'(5'h14));
        full_check();
        do_cmd(1'b1, 4'd0, 8'h00);
        chk("lane2_fine", 64'(odly_fine[8:6]), 64'(3'h5));
        full_check();

        // Overwrite before commit, multi-lane commit
        do_cmd(1'b0, 4'd1, 8'h10);
        do_cmd(1'b0, 4'd1, 8'h37);
        do_cmd(1'b0, 4'd6, 8'hFF);
        full_check();
        do_cmd(1'b1, 4'd0, 8'h00);
        full_check();

        // Empty commit
        do_cmd(1'b1, 4'd5, 8'h00);
        full_check();

        // Out-of-range lane
        do_cmd(1'b0, 4'd12, 8'h77);
        full_check();

        // cmd_valid held through stage and commit
        a0 = acc_cnt;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_lane = 4'd3; cmd_delay = 8'h5A;
        n = 0;
        while (acc_cnt == a0 && n < 20) begin @(posedge clk); #1; n++; end
        staged_m[3] = 8'h5A; dirty_m[3] = 1'b1;
        cmd_op = 1'b1;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 20) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        for (int i = 0; i < LANES; i++) applied_m[i] = staged_m[i];
        dirty_m = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("held_valid_accepts", 64'(acc_cnt - a0), 64'(2));
        @(negedge clk);
        full_check();

        // Reset during SETTLE
        do_cmd(1'b0, 4'd5, 8'hC3);
        send_cmd(1'b1, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        pulse_reset_and_check();
        ldn = 0; bsy = 0;
        repeat (8) begin
            @(negedge clk);
            if (odly_ld) ldn++;
            if (busy) bsy++;
        end
        chk("no_ld_after_rst", 64'(ldn), 64'(0));
        chk("no_busy_after_rst", 64'(bsy), 64'(0));
        full_check();

        // Reset between stage and commit discards the stage
        do_cmd(1'b0, 4'd4, 8'h9E);
        pulse_reset_and_check();
        @(negedge clk);
        do_cmd(1'b1, 4'd0, 8'h00);
        full_check();

        // Randomized command stream
        for (int k = 0; k < 40; k++) begin
            bit          op;
            logic [3:0]  ln;
            logic [7:0]  dl;
            op = ($urandom_range(0, 3) == 0);
            ln = 4'($urandom_range(0, 9));
            dl = 8'($urandom);
            do_cmd(op, ln, dl);
            if ((k % 4) == 3) full_check();
        end
        do_cmd(1'b1, 4'd0, 8'h00);
        full_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/odelay_pipe_loader.md
# odelay_pipe_loader

Multi-lane delay-setting sequencer for the output side of the memory PHY. It accepts per-lane 8-bit output-delay writes over a valid/ready command port and stages them into the lanes' ODELAYE2_FINEDELAY pipeline registers. On a commit command it applies every staged lane at once. It sits between the PHY control register bus and the per-lane output-delay primitives, so all DQ/DQS output delays of a byte group change on the same clock edge.

## Interface
- LANES, 8: number of controlled output-delay lanes (1..16).
- DELAY_VALUE, 0: 8-bit initial delay for every lane; [7:3] is coarse, [2:0] is fine.
- SETTLE_CYCLES, 4: cycles `busy` stays high after a commit (1..15).

- clk  in  1  clock for all logic and for the delay primitives' C input.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a clk edge where valid && ready.
- cmd_op  in  1  0 = stage lane delay, 1 = commit all staged lanes.
- cmd_lane  in  4  target lane for stage; ignored for commit.
- cmd_delay  in  8  delay value for stage: {coarse[4:0], fine[2:0]}.
- odly_cntvalue  out  5*LANES  per-lane CNTVALUEIN, lane i at [5i+4:5i].
- odly_ldpipeen  out  LANES  per-lane LDPIPEEN pulse.
- odly_ld  out  1  shared LD pulse to all lanes.
- odly_fine  out  3*LANES  per-lane OFDLY, lane i at [3i+2:3i].
- dirty  out  LANES  lane staged but not yet committed.
- busy  out  1  commit in progress or settling.
- bad_lane  out  1  sticky flag: a stage targeted cmd_lane >= LANES.
- rd_lane  in  4  readback lane select.
- rd_delay  out  8  applied delay of rd_lane, registered.

## Operation
- FSM states are IDLE, STAGE, COMMIT and SETTLE. `cmd_ready` = (state == IDLE) && !rst.
- IDLE, stage accepted, goes to STAGE.
  - For a valid lane: coarse register[lane] <= cmd_delay[7:3]; fine_pre[lane] <= cmd_delay[2:0]; staged[lane] <= cmd_delay; dirty[lane] <= 1.
  - For an invalid lane: no lane state changes; bad_lane <= 1.
- STAGE: `odly_ldpipeen[lane]` is high for exactly this cycle (none high for an invalid lane). Next state is IDLE.
- IDLE, commit accepted:
  - If `dirty` == 0, go to STAGE with no ldpipeen. This is a one-cycle no-op with no `odly_ld`.
  - Otherwise go to COMMIT.
- COMMIT: `odly_ld` is high for this cycle; busy = 1. On the closing edge, for every lane: odly_fine <= fine_pre, applied <= staged, dirty <= 0. Next state is SETTLE with counter = SETTLE_CYCLES-1.
- SETTLE: busy = 1. The counter decrements each cycle; the FSM goes to IDLE when the counter is 0.
- A lane written several times before a commit keeps only its last value.
- Non-dirty lanes also receive `odly_ld`. Their pipeline register still holds the applied coarse value, so their delay does not change.
- Readback: rd_delay <= applied[rd_lane] each cycle. If rd_lane >= LANES, rd_delay <= 0.
- Reset values (synchronous, take effect at the first clk edge with rst = 1):
  - odly_cntvalue lanes = DELAY_VALUE[7:3]; odly_fine lanes = DELAY_VALUE[2:0].
  - applied, staged and fine_pre = DELAY_VALUE.
  - odly_ld = 0, odly_ldpipeen = 0, dirty = 0, busy = 0, bad_lane = 0, rd_delay = DELAY_VALUE; state = IDLE.
- Reset mid-operation aborts immediately. A staged, uncommitted value is discarded and no pending pulses are issued.

## Timing
- Call the accept edge T.
  - Stage: ldpipeen is high in cycle T+1; cmd_ready is low in T+1 and high again in T+2. Peak throughput is one stage per 2 cycles.
  - Commit: odly_ld is high in T+1. odly_fine and rd_delay source values change at edge T+2, the same edge on which the primitive samples LD. busy is high from T+1 through T+1+SETTLE_CYCLES. cmd_ready returns in cycle T+2+SETTLE_CYCLES.
- odly_cntvalue changes on the accept edge and is stable while ldpipeen is high.
- rd_delay has 1-cycle latency from both rd_lane and the applied update.
- cmd_valid without cmd_ready is held off; no command is lost or duplicated.

## Test plan
- Reset with DELAY_VALUE=8'h2B -> all odly_cntvalue lanes = 5'h05, odly_fine = 3'h3, cmd_ready = 1 in the first cycle after rst falls, rd_delay = 8'h2B.
- Stage lane 2 = 8'hA5, then commit, SETTLE_CYCLES=4:
  - Lane 2 cntvalue = 5'h14 with ldpipeen[2] high for 1 cycle.
  - dirty = 8'h04 until the commit.
  - odly_ld high 1 cycle; fine[2] = 3'h5 after the LD edge.
  - busy high 5 cycles; rd_lane=2 gives rd_delay = 8'hA5.
- Stage lane 1 = 8'h10, then lane 1 = 8'h37, then lane 6 = 8'hFF, then commit -> lanes 1 and 6 read back 8'h37 and 8'hFF; all other lanes keep DELAY_VALUE; a single odly_ld pulse.
- Commit with dirty = 0 -> no odly_ld, busy stays 0, cmd_ready low for exactly 1 cycle.
- Stage lane 12 with LANES=8 -> bad_lane = 1 (sticky), no ldpipeen, dirty unchanged. Hold cmd_valid continuously through stage/commit -> each command is accepted exactly once.
- Assert rst during SETTLE and between stage and commit -> outputs return to their reset values at the next edge, dirty = 0, no odly_ld issued afterwards.
